// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: lane-partitioned Brent-Kung prefix adder/subtractor
// with a valid/ready pipeline of PIPE_STAGES registers (1..3).
//   stage boundaries: group P/G | up-sweep | down-sweep + sum -> output regs
//   PIPE_STAGES=1: output register only
//   PIPE_STAGES=2: + register after group P/G
//   PIPE_STAGES=3: + register after the up-sweep
// Optional feature macro: PREFIX_ADDER_OVF_EN adds the per-lane signed
// overflow output out_ovf; without it the port and its logic do not exist.
module pipelined_prefix_adder #(
  parameter int DATA_WIDTH  = 32,
  parameter int LANES       = 1,
  parameter int GROUP_SIZE  = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [LANES-1:0]      in_cin,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic [LANES-1:0]      out_cout
`ifdef PREFIX_ADDER_OVF_EN
  ,
  output logic [LANES-1:0]      out_ovf
`endif
);

  localparam int LW     = DATA_WIDTH / LANES;  // lane width
  localparam int NG     = LW / GROUP_SIZE;     // prefix leaves per lane
  localparam int TG     = DATA_WIDTH / GROUP_SIZE;
  localparam int LOG_NG = $clog2(NG);
  localparam int LAST   = PIPE_STAGES - 1;

  if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_pipe
    $fatal(1, "pipelined_prefix_adder: PIPE_STAGES must be 1..3");
  end
  if ((DATA_WIDTH % LANES) != 0 || (LW % GROUP_SIZE) != 0 || NG < 2 ||
      (1 << LOG_NG) != NG) begin : g_bad_geom
    $fatal(1, "pipelined_prefix_adder: lane groups must be a power of two >= 2");
  end

  // Operands (B already conditioned for subtract) plus per-group generate /
  // propagate. After the up-sweep, g/p hold the partial Brent-Kung spans.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [LANES-1:0]      cin;
    logic [TG-1:0]         g;
    logic [TG-1:0]         p;
  } pg_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] sum;
    logic [LANES-1:0]      cout;
`ifdef PREFIX_ADDER_OVF_EN
    logic [LANES-1:0]      ovf;
`endif
  } res_t;

  // Condition operands and reduce each GROUP_SIZE slice to one (G, P) pair.
  function automatic pg_t group_pg(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b,
                                   input logic [LANES-1:0] cin,
                                   input logic sub);
    pg_t  r;
    logic gg, pp;
    int   n;
    r     = '0;
    r.a   = a;
    r.b   = sub ? ~b : b;
    r.cin = sub ? '1 : cin;
    for (int j = 0; j < TG; j++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int i = 0; i < GROUP_SIZE; i++) begin
        n  = j * GROUP_SIZE + i;
        gg = (r.a[n] & r.b[n]) | ((r.a[n] ^ r.b[n]) & gg);
        pp = pp & (r.a[n] ^ r.b[n]);
      end
      r.g[j] = gg;
      r.p[j] = pp;
    end
    return r;
  endfunction

  // Brent-Kung up-sweep inside each lane; the top node ends up spanning the
  // whole lane, so lane carries never see a neighbouring lane.
  function automatic pg_t up_sweep(input pg_t x);
    pg_t r;
    int  j, m;
    r = x;
    for (int k = 0; k < LANES; k++) begin
      for (int l = 0; l < LOG_NG; l++) begin
        for (int i = 0; i < NG; i++) begin
          if (((i + 1) % (2 << l)) == 0) begin
            j      = k * NG + i;
            m      = j - (1 << l);
            r.g[j] = r.g[j] | (r.p[j] & r.g[m]);
            r.p[j] = r.p[j] & r.p[m];
          end
        end
      end
    end
    return r;
  endfunction

  // Down-sweep fills in the remaining prefixes, then each group ripples its
  // sum from a carry-in derived from the prefix and the lane carry-in.
  function automatic res_t finish(input pg_t x);
    res_t          r;
    logic [NG-1:0] gl, pl;
    logic          c;
    int            n, m;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      gl = x.g[k*NG +: NG];
      pl = x.p[k*NG +: NG];
      for (int l = LOG_NG - 2; l >= 0; l--) begin
        for (int i = 0; i < NG; i++) begin
          if (((i + 1) % (2 << l)) == (1 << l) && i >= (2 << l)) begin
            m     = i - (1 << l);
            gl[i] = gl[i] | (pl[i] & gl[m]);
            pl[i] = pl[i] & pl[m];
          end
        end
      end
      for (int i = 0; i < NG; i++) begin
        c = (i == 0) ? x.cin[k] : (gl[i-1] | (pl[i-1] & x.cin[k]));
        for (int t = 0; t < GROUP_SIZE; t++) begin
          n        = (k * NG + i) * GROUP_SIZE + t;
          r.sum[n] = x.a[n] ^ x.b[n] ^ c;
          c        = (x.a[n] & x.b[n]) | ((x.a[n] ^ x.b[n]) & c);
        end
      end
      r.cout[k] = gl[NG-1] | (pl[NG-1] & x.cin[k]);
`ifdef PREFIX_ADDER_OVF_EN
      n        = k * LW + LW - 1;
      r.ovf[k] = (x.a[n] == x.b[n]) & (r.sum[n] != x.a[n]);
`endif
    end
    return r;
  endfunction

  // ---------------- handshake ----------------
  logic [PIPE_STAGES-1:0] v;    // stage holds a beat
  logic [PIPE_STAGES-1:0] ld;   // stage may load this cycle
  logic [PIPE_STAGES-1:0] vin;  // valid presented to each stage
  logic [PIPE_STAGES-1:0] en;   // stage captures a real beat

  // Load chain from the output back: a stage loads if empty or its successor loads.
  always_comb begin : ld_chain
    logic nxt;
    // NOTE: every always_comb output gets a default before any branch or loop
    // so that no path can leave it unassigned and infer a latch.
    ld  = '0;
    nxt = out_ready;
    for (int s = LAST; s >= 0; s--) begin
      ld[s] = ~v[s] | nxt;
      nxt   = ld[s];
    end
  end

  assign in_ready  = rst_n & ld[0];
  assign out_valid = v[LAST];

  // Valid presented to each stage: the accepted input beat, then the predecessor.
  always_comb begin
    vin    = '0;
    vin[0] = in_valid & in_ready;
    for (int s = 1; s < PIPE_STAGES; s++) vin[s] = v[s-1];
  end

  assign en = ld & vin;

  // Valid bits advance whenever their stage loads; reset empties the pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      v <= '0;
    end else begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        if (ld[s]) v[s] <= vin[s];
      end
    end
  end

  // ---------------- datapath ----------------
  pg_t  pg_in, pg_s1, pg_up, pg_s2;
  res_t res;

  // Group generate/propagate straight from the input operands.
  always_comb pg_in = group_pg(in_a, in_b, in_cin, in_sub);

  if (PIPE_STAGES >= 2) begin : g_reg_pg
    // Capture group P/G when stage 0 takes a beat.
    always_ff @(posedge clk) begin
      // NOTE: payload registers carry no reset; the valid bits alone say
      // whether their contents mean anything.
      if (en[0]) pg_s1 <= pg_in;
    end
  end else begin : g_thru_pg
    assign pg_s1 = pg_in;
  end

  // Up-sweep on the group P/G.
  always_comb pg_up = up_sweep(pg_s1);

  if (PIPE_STAGES == 3) begin : g_reg_up
    // Capture the up-sweep result when stage 1 takes a beat.
    always_ff @(posedge clk) begin
      if (en[1]) pg_s2 <= pg_up;
    end
  end else begin : g_thru_up
    assign pg_s2 = pg_up;
  end

  // Down-sweep, group carries and ripple sums.
  always_comb res = finish(pg_s2);

  // Output registers: reset to zero and held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_sum  <= '0;
      out_cout <= '0;
`ifdef PREFIX_ADDER_OVF_EN
      out_ovf  <= '0;
`endif
    end else if (en[LAST]) begin
      out_sum  <= res.sum;
      out_cout <= res.cout;
`ifdef PREFIX_ADDER_OVF_EN
      out_ovf  <= res.ovf;
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// tb_pipelined_prefix_adder: drives pipelined_prefix_adder (4 lanes of 8 bits,
// GROUP_SIZE 2, three pipeline stages) with directed and random beats and
// checks every presented result against a per-lane arithmetic model.
// Build with PREFIX_ADDER_OVF_EN defined to also check out_ovf.
module tb_pipelined_prefix_adder;

  localparam int DW    = 32;
  localparam int LANES = 4;
  localparam int GS    = 2;
  localparam int PIPE  = 3;
  localparam int LW    = DW / LANES;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic [LANES-1:0] in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_sum;
  logic [LANES-1:0] out_cout;
`ifdef PREFIX_ADDER_OVF_EN
  logic [LANES-1:0] out_ovf;
`endif

  pipelined_prefix_adder #(
    .DATA_WIDTH (DW),
    .LANES      (LANES),
    .GROUP_SIZE (GS),
    .PIPE_STAGES(PIPE)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout)
`ifdef PREFIX_ADDER_OVF_EN
    ,
    .out_ovf  (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]    sum;
    logic [LANES-1:0] cout;
    logic [LANES-1:0] ovf;
  } exp_t;

  typedef struct {
    exp_t e;
    int   acc;
  } item_t;

  item_t q[$];
  int    checks     = 0;
  int    failures   = 0;
  int    cyc        = 0;
  int    last_stall = -1;
  int    ready_mode = 0;
  int    rcnt       = 0;
  bit    head_presented = 0;
  bit    hold_pending   = 0;
  bit    prev_rst_low   = 0;
  logic [DW-1:0]    hold_sum;
  logic [LANES-1:0] hold_cout;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-lane reference: plain (LW+1)-bit addition.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [LANES-1:0] cin, input logic sub);
    exp_t          r;
    logic [LW:0]   t;
    logic [LW-1:0] ak, bk;
    r.sum  = '0;
    r.cout = '0;
    r.ovf  = '0;
    for (int k = 0; k < LANES; k++) begin
      ak = a[k*LW +: LW];
      bk = sub ? ~b[k*LW +: LW] : b[k*LW +: LW];
      t  = {1'b0, ak} + {1'b0, bk} + {{LW{1'b0}}, (sub | cin[k])};
      r.sum[k*LW +: LW] = t[LW-1:0];
      r.cout[k]         = t[LW];
      r.ovf[k]          = (ak[LW-1] == bk[LW-1]) && (t[LW-1] != ak[LW-1]);
    end
    return r;
  endfunction

  // out_ready pattern generator.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((rcnt % 3) == 0);
      2:       out_ready = 1'b0;
      default: out_ready = (($urandom % 4) != 0);
    endcase
    rcnt++;
  end

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("rst_in_ready", 64'(in_ready), 64'(0));
      if (prev_rst_low) check("rst_out_valid", 64'(out_valid), 64'(0));
      q.delete();
      head_presented = 0;
      hold_pending   = 0;
      prev_rst_low   = 1;
    end else begin
      prev_rst_low = 0;
      check("in_ready", 64'(in_ready), 64'(!(q.size() == PIPE && !out_ready)));
      check("inflight_bound", 64'(q.size() <= PIPE), 64'(1));
      if (hold_pending) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_sum", 64'(out_sum), 64'(hold_sum));
        check("stall_cout", 64'(out_cout), 64'(hold_cout));
      end
      if (q.size() == 0) begin
        check("idle_out_valid", 64'(out_valid), 64'(0));
      end else if (out_valid) begin
        check("sum", 64'(out_sum), 64'(q[0].e.sum));
        check("cout", 64'(out_cout), 64'(q[0].e.cout));
`ifdef PREFIX_ADDER_OVF_EN
        check("ovf", 64'(out_ovf), 64'(q[0].e.ovf));
`endif
        if (!head_presented) begin
          head_presented = 1;
          if (last_stall < q[0].acc) check("latency", 64'(cyc - q[0].acc), 64'(PIPE));
        end
        if (out_ready) begin
          void'(q.pop_front());
          head_presented = 0;
        end
      end
      hold_pending = out_valid & ~out_ready;
      hold_sum     = out_sum;
      hold_cout    = out_cout;
      if (!out_ready) last_stall = cyc;
      if (in_valid && in_ready) begin
        item_t it;
        it.e   = model(in_a, in_b, in_cin, in_sub);
        it.acc = cyc;
        q.push_back(it);
      end
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [LANES-1:0] cin, input logic sub);
    logic acc;
    acc      = 1'b0;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("accept_timeout", 64'(acc), 64'(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain", 64'(q.size()), 64'(0));
    idle(3);
  endtask

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic [DW-1:0] ra, rb;
    // Reset held for three edges with a beat offered.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_a     = 32'h1234_5678;
    in_b     = 32'h1111_1111;
    in_cin   = '0;
    in_sub   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idle(4);

    // Hand-computed values pinning the model.
    e = model(32'h01FF80FF, 32'h01018001, 4'b0000, 1'b0);
    check("pin_lanes_sum", 64'(e.sum), 64'h0200_0000);
    check("pin_lanes_cout", 64'(e.cout), 64'(4'b0111));
    check("pin_lanes_ovf", 64'(e.ovf), 64'(4'b0010));
    e = model(32'hFFFFFFFF, 32'h00000001, 4'b0000, 1'b0);
    check("pin_wrap_sum", 64'(e.sum), 64'hFFFF_FF00);
    check("pin_wrap_cout", 64'(e.cout), 64'(4'b0001));
    e = model(32'hFFFFFFFF, 32'h00000001, 4'b1111, 1'b0);
    check("pin_cin_sum", 64'(e.sum), 64'h0000_0001);
    check("pin_cin_cout", 64'(e.cout), 64'(4'b1111));
    e = model(32'h00050003, 32'h00030005, 4'b1010, 1'b1);
    check("pin_sub_sum", 64'(e.sum), 64'h0002_00FE);
    check("pin_sub_cout", 64'(e.cout), 64'(4'b1110));
    e = model(32'h7F7F7F7F, 32'h01010101, 4'b0000, 1'b0);
    check("pin_ovf_sum", 64'(e.sum), 64'h8080_8080);
    check("pin_ovf_flags", 64'(e.ovf), 64'(4'b1111));
    e = model(32'h80808080, 32'h01010101, 4'b0000, 1'b1);
    check("pin_subovf_sum", 64'(e.sum), 64'h7F7F_7F7F);
    check("pin_subovf_cout", 64'(e.cout), 64'(4'b1111));
    check("pin_subovf_flags", 64'(e.ovf), 64'(4'b1111));

    // Directed beats through the DUT, consumer always ready.
    ready_mode = 0;
    send(32'hFFFFFFFF, 32'h00000001, 4'b0000, 1'b0);
    idle(5);
    send(32'hFFFFFFFF, 32'h00000001, 4'b1111, 1'b0);
    send(32'h01FF80FF, 32'h01018001, 4'b0000, 1'b0);
    send(32'h00050003, 32'h00030005, 4'b1010, 1'b1);
    send(32'h7F7F7F7F, 32'h01010101, 4'b0000, 1'b0);
    send(32'h80808080, 32'h01010101, 4'b0101, 1'b1);
    send(32'h00000000, 32'h00000000, 4'b0000, 1'b1);
    drain();

    // Ten back-to-back beats under a 1,0,0 ready pattern.
    ready_mode = 1;
    for (int i = 0; i < 10; i++) begin
      send($urandom, $urandom, 4'($urandom), 1'(i % 3 == 2));
    end
    drain();

    // Fill the pipe while stalled, then reset: nothing may come out afterwards.
    ready_mode = 2;
    idle(2);
    for (int i = 0; i < PIPE; i++) send($urandom, $urandom, 4'($urandom), 1'b0);
    rst_n = 1'b0;
    idle(2);
    rst_n      = 1'b1;
    ready_mode = 0;
    idle(10);

    // Random traffic with random backpressure and gaps.
    ready_mode = 3;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom % 8)
        0:       ra = 32'hFFFFFFFF;
        1:       ra = 32'h80808080;
        2:       ra = 32'h7F7F7F7F;
        default: ra = $urandom;
      endcase
      rb = (($urandom % 8) == 0) ? ~ra : $urandom;
      send(ra, rb, 4'($urandom), 1'(($urandom % 4) == 0));
      if (($urandom % 5) == 0) idle(1 + ($urandom % 3));
    end
    ready_mode = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
